// File: rtl/req_arbiter_if.sv
// ---------------------------------------------------------------------------
// req_arbiter_if
//   Request/grant bundle between the requesters and req_arbiter.
//
//   Signals (N = number of requesters):
//     req_async [N-1:0]          level requests, may be asynchronous to clk
//     done                       release strobe from the current grant holder
//     gnt       [N-1:0]          one-hot grant
//     gnt_id    [$clog2(N)-1:0]  index of the current or last grant
//     busy                       high while a grant is held
//     pend      [N-1:0]          pending-request vector
//     timeout                    one-cycle pulse when a grant is revoked by the hold limit
//
//   Modports:
//     master  requester side: drives req_async/done, observes the rest
//     slave   arbiter side:   the reverse
// ---------------------------------------------------------------------------
interface req_arbiter_if #(
    parameter int unsigned N = 4
) ();

    logic [N-1:0]         req_async;
    logic                 done;
    logic [N-1:0]         gnt;
    logic [$clog2(N)-1:0] gnt_id;
    logic                 busy;
    logic [N-1:0]         pend;
    logic                 timeout;

    modport master (
        output req_async,
        output done,
        input  gnt,
        input  gnt_id,
        input  busy,
        input  pend,
        input  timeout
    );

    modport slave (
        input  req_async,
        input  done,
        output gnt,
        output gnt_id,
        output busy,
        output pend,
        output timeout
    );

endinterface

// File: rtl/req_arbiter.sv
// ---------------------------------------------------------------------------
// req_arbiter
//   Round-robin arbiter for N requesters whose requests arrive as levels from
//   foreign or asynchronous sources. Each request is synchronised with two flops,
//   and a third flop keeps the previous synchronised value. A rising edge on the
//   synchronised request latches a pending bit. Grants are one-hot and registered.
//   Each grant lasts until the holder pulses done. Consecutive grants are
//   separated by exactly one RELEASE cycle with gnt low.
//
//   Parameters:
//     N     number of requesters (2..16)
//     HOLD  maximum grant length in cycles (2..255); used only with ARB_TIMEOUT_EN
//
//   Ports:
//     clk   rising-edge clock
//     res   synchronous active-high reset
//     bus   req_arbiter_if.slave: req_async, done in; gnt, gnt_id, busy, pend,
//           timeout out
//
//   Build option:
//     ARB_TIMEOUT_EN  when defined, a grant held for HOLD cycles without done is
//                     revoked and timeout pulses for the following RELEASE cycle.
//                     When undefined, grants persist until done and timeout is 0.
// ---------------------------------------------------------------------------
module req_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned HOLD = 8
) (
    input logic          clk,
    input logic          res,
    req_arbiter_if.slave bus
);

    localparam int unsigned IdW = $clog2(N);

    // Elaboration-time parameter range checks.
    if (N < 2 || N > 16) begin : g_bad_n
        $error("req_arbiter: N must be in 2..16");
    end
    if (HOLD < 2 || HOLD > 255) begin : g_bad_hold
        $error("req_arbiter: HOLD must be in 2..255");
    end

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StRelease
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   sync1_q, sync2_q, prev_q;
    logic [N-1:0]   rise;
    logic [N-1:0]   pend_q, pend_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IdW-1:0] gnt_id_q, gnt_id_d;
    logic [IdW-1:0] last_q, last_d;
    logic [IdW-1:0] win_idx;
    logic [N-1:0]   clr;
    logic           enter_grant;

`ifdef ARB_TIMEOUT_EN
    logic [7:0]     cnt_q, cnt_d;
    logic           timeout_q, timeout_d;
`endif

    // ------------------------------------------------------------------
    // Request synchroniser and edge detector
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (res) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= bus.req_async;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Only a 0->1 transition requests; a level that stays high does not re-request.
    assign rise = sync2_q & ~prev_q;

    // ------------------------------------------------------------------
    // Round-robin winner: first pending bit searching upward from last+1
    // ------------------------------------------------------------------
    always_comb begin
        logic           found;
        logic [IdW-1:0] cand;
        found   = 1'b0;
        cand    = '0;
        win_idx = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = IdW'((32'(last_q) + i) % N);
            if (!found && pend_q[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and registered-output next values
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        last_d      = last_q;
        clr         = '0;
        enter_grant = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                enter_grant = |pend_q;
            end
            StGrant: begin
                // done takes precedence over the hold limit in the same cycle.
                if (bus.done) begin
                    state_d = StRelease;
                    gnt_d   = '0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == 8'(HOLD - 1)) begin
                    state_d   = StRelease;
                    gnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            StRelease: begin
                if (|pend_q) begin
                    enter_grant = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase

        if (enter_grant) begin
            state_d  = StGrant;
            gnt_d    = {{(N-1){1'b0}}, 1'b1} << win_idx;
            gnt_id_d = win_idx;
            last_d   = win_idx;
            clr      = gnt_d;
`ifdef ARB_TIMEOUT_EN
            cnt_d    = '0;
`endif
        end

        // A fresh edge for the winner wins over its clear on the same cycle.
        pend_d = (pend_q & ~clr) | rise;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (res) begin
            state_q  <= StIdle;
            pend_q   <= '0;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            // Index 0 gets first priority after reset.
            last_q   <= IdW'(N - 1);
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            last_q   <= last_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (res) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.gnt    = gnt_q;
    assign bus.gnt_id = gnt_id_q;
    assign bus.busy   = (state_q == StGrant);
    assign bus.pend   = pend_q;

endmodule

// File: doc/req_arbiter.md
REQ_ARBITER -- requirements
Module: req_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters; legal range 2..16.
REQ-002 Parameter HOLD, default 8: maximum grant length in cycles; legal range 2..255; used only when ARB_TIMEOUT_EN is defined.
REQ-003 Reset is synchronous and active-high on port res; the block has one clock, clk.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 res  input  1  synchronous active-high reset.
REQ-006 req_async  input  N  level requests from foreign or asynchronous sources, one bit per requester.
REQ-007 done  input  1  resource-release strobe from the current grant holder; sampled only in GRANT.
REQ-008 gnt  output  N  one-hot grant, registered.
REQ-009 gnt_id  output  $clog2(N)  binary index of the current or last grant, registered.
REQ-010 busy  output  1  high while state is GRANT.
REQ-011 pend  output  N  pending-request vector, registered.
REQ-012 timeout  output  1  one-cycle pulse when a grant is revoked by the HOLD limit.

Function
REQ-013 Each req_async bit SHALL pass through a two-stage flop synchroniser; a third flop SHALL hold the previous synchronised value.
REQ-014 A rising edge (sync=1, prev=0) SHALL set the matching pend bit on the next clock edge; levels that stay high SHALL NOT re-request.
REQ-015 FSM states: IDLE, GRANT, RELEASE.
REQ-016 IDLE: if pend != 0, go to GRANT on the next edge; otherwise stay in IDLE.
REQ-017 GRANT: hold gnt stable; on done=1 (or on timeout, see REQ-026), go to RELEASE.
REQ-018 RELEASE: gnt=0 for exactly one cycle; then go to GRANT if pend != 0, otherwise go to IDLE.
REQ-019 Entering GRANT SHALL select the winner round-robin: search from index last+1 upward, wrapping modulo N. last SHALL be updated to the winner.
REQ-020 Entering GRANT SHALL set gnt to one-hot(winner) and gnt_id to winner, and SHALL clear pend[winner] on the same edge.
REQ-021 If a new rising edge for the winner coincides with its clear, set SHALL take priority and pend[winner] SHALL remain 1.
REQ-022 Latency: with req_async sampled high at edge 1 and the FSM in IDLE with pend=0, gnt SHALL rise after edge 4.
REQ-023 gnt SHALL be 0 in IDLE and RELEASE; gnt_id SHALL retain the last winner.
REQ-024 done SHALL be ignored outside GRANT.
REQ-025 Back-to-back grants SHALL be separated by exactly one gnt-low cycle.

Reset
REQ-026 Timeout: a counter SHALL clear on GRANT entry and increment each GRANT cycle. When it reaches HOLD-1 with done=0, the next edge SHALL enter RELEASE with timeout=1 for that RELEASE cycle.
REQ-027 If done=1 in the same cycle the count reaches HOLD-1, done SHALL win and timeout SHALL stay 0.
REQ-028 Reset SHALL set the following on the next edge: state IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, pend=0, all synchroniser and prev flops 0, last=N-1 (so index 0 has first priority), timeout counter 0.
REQ-029 Reset asserted mid-grant SHALL drop gnt on the next edge and discard all pending requests; a request held high through reset SHALL re-request after release, as a 0-to-1 synchronised edge.

Configuration
REQ-030 Macro ARB_TIMEOUT_EN: when defined, the HOLD counter and timeout behaviour SHALL be compiled in (REQ-026, REQ-027).
REQ-031 When ARB_TIMEOUT_EN is undefined, the grant SHALL persist until done, the counter SHALL be absent, timeout SHALL be tied 0, and HOLD SHALL be unused.

Verification (N=4, HOLD=8)
REQ-032 req_async=0001 from reset, done pulsed 3 cycles into the grant -> gnt=0001, gnt_id=0 after edge 4; RELEASE one cycle; then IDLE with gnt=0000.
REQ-033 req_async rising 1111 simultaneously, done pulsed each grant -> grant order 0,1,2,3, each separated by one gnt-low cycle; pend goes 1111 -> 1110 -> 1100 -> 1000 -> 0000.
REQ-034 Two runs compare macro settings, req_async=0100 with done never asserted:
- ARB_TIMEOUT_EN defined -> gnt=0100 for 8 cycles, then timeout=1 for one cycle with gnt=0000.
- ARB_TIMEOUT_EN undefined -> gnt held indefinitely and timeout stays 0.
REQ-035 done=1 in grant cycle 8 (count=7) -> RELEASE with timeout=0.
REQ-036 Reset in grant cycle 2 with pend=1010 -> next edge gnt=0000, pend=0000, busy=0; req_async held at 0010 -> gnt=0010 after 4 edges post-reset.
REQ-037 req_async bit 2 toggled 0-1-0-1 (each level 3 cycles) while bit 2 is being granted -> pend[2] re-set despite the simultaneous clear; bit 2 granted again once the round-robin search from index 3 (wrapping) reaches it.
